skid_fifo_buffer: RTL and testbench



---
 rtl/skid_pkg.sv | 26 ++
 rtl/skid_storage.sv | 40 ++++
 rtl/skid_fifo_buffer.sv | 142 ++++++++++++++
 tb/tb_skid_fifo_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// ---------------------------------------------------------------------------
// skid_pkg
// Shared definitions for the skid FIFO buffer and the mailbox top that
// instantiates it.
//   SKID_DATA_WIDTH / SKID_DEPTH : default payload width and buffer depth
//   cnt_w(depth) : width needed to hold a fill level of 0..depth
//   ptr_w(depth) : width needed to address depth entries (never below 1)
// ---------------------------------------------------------------------------
package skid_pkg;

    localparam int SKID_DATA_WIDTH = 32;
    localparam int SKID_DEPTH      = 4;

    // A fill level must represent both empty (0) and full (depth).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A depth of 1 would give $clog2 = 0, so clamp to a one-bit pointer.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/skid_storage.sv
// ---------------------------------------------------------------------------
// skid_storage
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. Data is never reset; the owning logic tracks which
// entries are valid.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module skid_storage
    import skid_pkg::*;
#(
    parameter int DATA_WIDTH = SKID_DATA_WIDTH,
    parameter int DEPTH      = SKID_DEPTH,
    parameter int PTR_W      = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] storage_q [DEPTH];

    // Plain write port; addresses beyond DEPTH-1 are never produced by the
    // pointer logic, so no range guard is needed here.
    always_ff @(posedge clk) begin
        if (we_i) begin
            storage_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = storage_q[raddr_i];

endmodule

// File: rtl/skid_fifo_buffer.sv
// ---------------------------------------------------------------------------
// skid_fifo_buffer
// Elastic valid/ready buffer of configurable depth. in_ready_o is derived
// from the registered fill level only, which cuts the combinational ready
// path from the consumer back to the producer.
//   clk, rst     : clock and asynchronous active-high reset
//   flush_i      : synchronous clear of all stored entries
//   in_valid_i   : upstream beat valid
//   in_ready_o   : buffer can accept a beat
//   data_in      : upstream payload
//   out_valid_o  : downstream beat valid
//   out_ready_i  : downstream accepts beat
//   data_out     : downstream payload
//   count_o      : number of stored entries
//   afull_o      : count_o >= AFULL_LVL
// REG_OUT=1 always presents data from storage; REG_OUT=0 lets a beat fall
// straight through while the buffer is empty.
// ---------------------------------------------------------------------------
module skid_fifo_buffer
    import skid_pkg::*;
#(
    parameter int DATA_WIDTH = SKID_DATA_WIDTH,
    parameter int DEPTH      = SKID_DEPTH,
    parameter int REG_OUT    = 1,
    parameter int AFULL_LVL  = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [cnt_w(DEPTH)-1:0]  count_o,
    output logic                     afull_o
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam bit            BYPASS    = (REG_OUT == 0);

    logic [PW-1:0]         wrPtr_q, wrPtr_d;
    logic [PW-1:0]         rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  isEmpty, isFull;
    logic                  push, pop, passThrough, doWrite, doRead;
    logic [DATA_WIDTH-1:0] rdData;

    skid_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PW)
    ) u_storage (
        .clk     (clk),
        .we_i    (doWrite),
        .waddr_i (wrPtr_q),
        .wdata_i (data_in),
        .raddr_i (rdPtr_q),
        .rdata_o (rdData)
    );

    assign isEmpty    = (count_q == '0);
    assign isFull     = (count_q == FULL_CNT);
    assign in_ready_o = ~isFull;
    assign count_o    = count_q;
    assign afull_o    = (count_q >= AFULL_CNT);

    // Output side: storage head when holding data. An empty registered
    // buffer drives zeros so data_out is defined out of reset; an empty
    // bypass buffer mirrors the upstream channel directly.
    always_comb begin
        out_valid_o = ~isEmpty;
        data_out    = isEmpty ? '0 : rdData;
        if (BYPASS && isEmpty) begin
            out_valid_o = in_valid_i;
            data_out    = data_in;
        end
    end

    // A beat that passes straight through never touches storage, so it
    // must not move the pointers or the count. Flush overrides everything
    // that would otherwise modify stored state.
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign passThrough = BYPASS & isEmpty & push & out_ready_i;
    assign doWrite     = push & ~passThrough & ~flush_i;
    assign doRead      = pop & ~passThrough & ~flush_i;

    // Next-state for pointers and fill level. Pointers wrap by explicit
    // compare so non-power-of-two depths use every entry.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            end
            if (doRead) begin
                rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
            end
            case ({doWrite, doRead})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Structural invariants of the buffer and the downstream handshake.
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_CNT);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && isFull));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(data_out)));

endmodule

// File: tb/tb_skid_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_skid_fifo_buffer
// Three buffer instances share clock and reset:
//   0 : DEPTH=4, REG_OUT=1
//   1 : DEPTH=3, REG_OUT=1 (non-power-of-two wrap)
//   2 : DEPTH=4, REG_OUT=0 (bypass)
// Directed scenarios use constant expectations; the random scenario compares
// every instance against a queue model of the buffer.
// ---------------------------------------------------------------------------
module tb_skid_fifo_buffer;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      flush, inValid, outReady;
    logic [2:0]      inReady, outValid, afull;
    logic [2:0][7:0] dataIn, dataOut;
    logic [2:0]      count0;
    logic [1:0]      count1;
    logic [2:0]      count2;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    skid_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4), .REG_OUT(1)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush[0]),
        .in_valid_i(inValid[0]), .in_ready_o(inReady[0]), .data_in(dataIn[0]),
        .out_valid_o(outValid[0]), .out_ready_i(outReady[0]), .data_out(dataOut[0]),
        .count_o(count0), .afull_o(afull[0]));

    skid_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(3), .REG_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush[1]),
        .in_valid_i(inValid[1]), .in_ready_o(inReady[1]), .data_in(dataIn[1]),
        .out_valid_o(outValid[1]), .out_ready_i(outReady[1]), .data_out(dataOut[1]),
        .count_o(count1), .afull_o(afull[1]));

    skid_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4), .REG_OUT(0)) dut2 (
        .clk(clk), .rst(rst), .flush_i(flush[2]),
        .in_valid_i(inValid[2]), .in_ready_o(inReady[2]), .data_in(dataIn[2]),
        .out_valid_o(outValid[2]), .out_ready_i(outReady[2]), .data_out(dataOut[2]),
        .count_o(count2), .afull_o(afull[2]));

    // Per-instance configuration as seen by the model.
    function automatic int depthOf(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    function automatic bit regOf(input int d);
        return (d != 2);
    endfunction

    function automatic int cntOf(input int d);
        case (d)
            0:       return int'(count0);
            1:       return int'(count1);
            default: return int'(count2);
        endcase
    endfunction

    // Queue model helpers.
    function automatic int mSize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] mFront(input int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic mPush(input int d, input logic [7:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic mPop(input int d);
        case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic mClear(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic idleInputs();
        flush    = '0;
        inValid  = '0;
        outReady = '0;
        dataIn   = '0;
    endtask

    // Reset state of all three instances, during and after reset.
    task automatic test_reset();
        idleInputs();
        dataIn[2] = 8'h3C;
        rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++; if (inReady[d] !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b want 1", d, inReady[d]); end
            checks++; if (outValid[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", d, outValid[d]); end
            checks++; if (cntOf(d) != 0) begin errors++; $display("[TB] FAIL reset_count[%0d]: got %0d want 0", d, cntOf(d)); end
            checks++; if (afull[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull[%0d]: got %b want 0", d, afull[d]); end
        end
        checks++; if (dataOut[0] !== 8'h00) begin errors++; $display("[TB] FAIL reset_data0: got %h want 00", dataOut[0]); end
        checks++; if (dataOut[2] !== 8'h3C) begin errors++; $display("[TB] FAIL reset_bypass_data: got %h want 3c", dataOut[2]); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (count0 !== 3'd0 || inReady[0] !== 1'b1 || outValid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset0: count %0d ready %b valid %b want 0 1 0", count0, inReady[0], outValid[0]);
        end
        dataIn[2] = 8'h00;
    endtask

    // Fill instance 0 to full with backpressure; fifth beat is refused.
    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inValid[0] = 1'b1; dataIn[0] = 8'hA0 + 8'(i); outReady[0] = 1'b0;
            #1;
            checks++; if (count0 !== 3'(i)) begin errors++; $display("[TB] FAIL fill_count: got %0d want %0d", count0, i); end
            checks++; if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready: got %b want 1", inReady[0]); end
            checks++; if (afull[0] !== (i >= 3)) begin errors++; $display("[TB] FAIL fill_afull: got %b want %b at count %0d", afull[0], (i >= 3), i); end
        end
        @(negedge clk);
        dataIn[0] = 8'hA4;
        #1;
        checks++; if (count0 !== 3'd4 || inReady[0] !== 1'b0 || afull[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL full_flags: count %0d ready %b afull %b want 4 0 1", count0, inReady[0], afull[0]);
        end
        checks++; if (outValid[0] !== 1'b1 || dataOut[0] !== 8'hA0) begin
            errors++; $display("[TB] FAIL full_head: valid %b data %h want 1 a0", outValid[0], dataOut[0]);
        end
        @(negedge clk);
        inValid[0] = 1'b0;
        #1;
        checks++; if (count0 !== 3'd4) begin errors++; $display("[TB] FAIL full_refuse: got %0d want 4", count0); end
    endtask

    // Drain instance 0 in order; ready reopens one cycle after the first pop.
    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inValid[0] = 1'b0; outReady[0] = 1'b1;
            #1;
            checks++; if (outValid[0] !== 1'b1 || dataOut[0] !== 8'hA0 + 8'(i)) begin
                errors++; $display("[TB] FAIL drain_data: valid %b data %h want 1 %h", outValid[0], dataOut[0], 8'hA0 + 8'(i));
            end
            checks++; if (inReady[0] !== (i != 0)) begin errors++; $display("[TB] FAIL drain_ready: got %b want %b beat %0d", inReady[0], (i != 0), i); end
        end
        @(negedge clk);
        outReady[0] = 1'b0;
        #1;
        checks++; if (outValid[0] !== 1'b0 || count0 !== 3'd0) begin
            errors++; $display("[TB] FAIL drain_empty: valid %b count %0d want 0 0", outValid[0], count0);
        end
    endtask

    // Instance 1 (DEPTH=3): stream 1..10 with push and pop together.
    task automatic test_back_to_back();
        @(negedge clk);
        inValid[1] = 1'b1; dataIn[1] = 8'd1; outReady[1] = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            dataIn[1] = 8'(k); outReady[1] = 1'b1;
            #1;
            checks++; if (count1 !== 2'd1) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 1", count1); end
            checks++; if (outValid[1] !== 1'b1 || dataOut[1] !== 8'(k - 1)) begin
                errors++; $display("[TB] FAIL b2b_data: valid %b data %0d want 1 %0d", outValid[1], dataOut[1], k - 1);
            end
        end
        @(negedge clk);
        inValid[1] = 1'b0;
        #1;
        checks++; if (dataOut[1] !== 8'd10 || count1 !== 2'd1) begin
            errors++; $display("[TB] FAIL b2b_last: data %0d count %0d want 10 1", dataOut[1], count1);
        end
        @(negedge clk);
        outReady[1] = 1'b0;
        #1;
        checks++; if (count1 !== 2'd0 || outValid[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_empty: count %0d valid %b want 0 0", count1, outValid[1]);
        end
    endtask

    // Instance 2 (REG_OUT=0): pass-through when empty, then capture on stall.
    task automatic test_bypass();
        @(negedge clk);
        inValid[2] = 1'b1; dataIn[2] = 8'h55; outReady[2] = 1'b1;
        #1;
        checks++; if (outValid[2] !== 1'b1 || dataOut[2] !== 8'h55) begin
            errors++; $display("[TB] FAIL bypass_pass: valid %b data %h want 1 55", outValid[2], dataOut[2]);
        end
        @(negedge clk);
        outReady[2] = 1'b0;
        #1;
        checks++; if (count2 !== 3'd0) begin errors++; $display("[TB] FAIL bypass_nocount: got %0d want 0", count2); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inValid[2] = 1'b0; dataIn[2] = 8'($urandom);
            #1;
            checks++; if (count2 !== 3'd1 || outValid[2] !== 1'b1 || dataOut[2] !== 8'h55) begin
                errors++; $display("[TB] FAIL bypass_hold: count %0d valid %b data %h want 1 1 55", count2, outValid[2], dataOut[2]);
            end
        end
        @(negedge clk);
        outReady[2] = 1'b1;
        @(negedge clk);
        outReady[2] = 1'b0;
        #1;
        checks++; if (count2 !== 3'd0 || outValid[2] !== 1'b0) begin
            errors++; $display("[TB] FAIL bypass_drain: count %0d valid %b want 0 0", count2, outValid[2]);
        end
    endtask

    // Flush beats a simultaneous push and pop; next push is output first.
    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            inValid[0] = 1'b1; dataIn[0] = (i == 0) ? 8'h11 : 8'h22; outReady[0] = 1'b0;
        end
        @(negedge clk);
        flush[0] = 1'b1; inValid[0] = 1'b1; dataIn[0] = 8'h33; outReady[0] = 1'b1;
        #1;
        checks++; if (count0 !== 3'd2 || dataOut[0] !== 8'h11) begin
            errors++; $display("[TB] FAIL flush_pre: count %0d data %h want 2 11", count0, dataOut[0]);
        end
        @(negedge clk);
        flush[0] = 1'b0; inValid[0] = 1'b0; outReady[0] = 1'b0;
        #1;
        checks++; if (count0 !== 3'd0 || outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_clear: count %0d valid %b ready %b want 0 0 1", count0, outValid[0], inReady[0]);
        end
        @(negedge clk);
        inValid[0] = 1'b1; dataIn[0] = 8'h44;
        @(negedge clk);
        inValid[0] = 1'b0;
        #1;
        checks++; if (outValid[0] !== 1'b1 || dataOut[0] !== 8'h44 || count0 !== 3'd1) begin
            errors++; $display("[TB] FAIL flush_next: valid %b data %h count %0d want 1 44 1", outValid[0], dataOut[0], count0);
        end
        @(negedge clk);
        outReady[0] = 1'b1;
        @(negedge clk);
        outReady[0] = 1'b0;
    endtask

    // Held beat stays stable under backpressure; async reset clears at once.
    task automatic test_backpressure_reset();
        @(negedge clk);
        inValid[0] = 1'b1; dataIn[0] = 8'h77; outReady[0] = 1'b0;
        @(negedge clk);
        inValid[0] = 1'b0; dataIn[0] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (outValid[0] !== 1'b1 || dataOut[0] !== 8'h77) begin
                errors++; $display("[TB] FAIL hold_data: valid %b data %h want 1 77", outValid[0], dataOut[0]);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (outValid[0] !== 1'b0 || count0 !== 3'd0 || inReady[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset: valid %b count %0d ready %b want 0 0 1", outValid[0], count0, inReady[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random traffic on all instances against the queue model.
    task automatic test_random();
        int         sz;
        bit         expReady, expValid, doPush, doPop;
        logic [7:0] expData;
        for (int d = 0; d < 3; d++) mClear(d);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                inValid[d]  = ($urandom_range(0, 3) != 0);
                outReady[d] = ($urandom_range(0, 2) != 0);
                flush[d]    = ($urandom_range(0, 24) == 0);
                dataIn[d]   = 8'($urandom);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                sz       = mSize(d);
                expReady = (sz < depthOf(d));
                expValid = (sz > 0) || (!regOf(d) && inValid[d]);
                expData  = (sz > 0) ? mFront(d) : (regOf(d) ? 8'h00 : dataIn[d]);
                checks++; if (inReady[d] !== expReady) begin errors++; $display("[TB] FAIL rnd_ready[%0d] cyc %0d: got %b want %b", d, cyc, inReady[d], expReady); end
                checks++; if (outValid[d] !== expValid) begin errors++; $display("[TB] FAIL rnd_valid[%0d] cyc %0d: got %b want %b", d, cyc, outValid[d], expValid); end
                checks++; if (dataOut[d] !== expData) begin errors++; $display("[TB] FAIL rnd_data[%0d] cyc %0d: got %h want %h", d, cyc, dataOut[d], expData); end
                checks++; if (cntOf(d) != sz) begin errors++; $display("[TB] FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", d, cyc, cntOf(d), sz); end
                checks++; if (afull[d] !== (sz >= depthOf(d) - 1)) begin errors++; $display("[TB] FAIL rnd_afull[%0d] cyc %0d: got %b want %b", d, cyc, afull[d], (sz >= depthOf(d) - 1)); end
                doPush = inValid[d] && expReady;
                doPop  = expValid && outReady[d];
                if (flush[d]) begin
                    mClear(d);
                end else begin
                    if (doPop && sz > 0) mPop(d);
                    if (doPush && !(doPop && sz == 0)) mPush(d, dataIn[d]);
                end
            end
        end
        @(negedge clk);
        idleInputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_bypass();
        test_flush();
        test_backpressure_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
